apb_dpmem: RTL and testbench

//  APB (AMBA3/APB4-style) slave wrapping a word-addressed RAM with byte-lane write strobes.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_dpmem_ram.sv | 53 +++++
 rtl/apb_dpmem.sv | 122 ++++++++++++
 tb/tb_apb_dpmem.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, bus-phase enum and word typedefs.
package apb_pkg;

   localparam int APB_ADDR_WIDTH = 32;
   localparam int APB_DATA_WIDTH = 32;

   // Bus phase of a cycle as seen by the slave.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   typedef logic [APB_ADDR_WIDTH-1:0] addr_t;
   typedef logic [APB_DATA_WIDTH-1:0] data_t;

endpackage

// File: rtl/apb_dpmem_ram.sv
// Word-addressed RAM built from one byte-wide array per lane.
// One byte-strobed write port, one registered read port that returns 0 when
// not enabled, and an asynchronous clear of every word on rst_n.
module apb_dpmem_ram #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 256,
   parameter int IDX_W      = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_WIDTH-1:0]   wr_data,
   input  logic [DATA_WIDTH/8-1:0] wr_strb,
   input  logic                    rd_en,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [DATA_WIDTH-1:0]   rd_data
);

   localparam int LANES = DATA_WIDTH / 8;

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem_q [DEPTH];
      logic [7:0] rd_q;
      logic [7:0] rd_d;

      // Read data is the addressed byte when enabled, otherwise zero.
      always_comb begin
         rd_d = 8'h00;
         if (rd_en) begin
            rd_d = mem_q[rd_idx];
         end
      end

      // Lane storage and read register; reset clears every word.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
               mem_q[i] <= 8'h00;
            end
            rd_q <= 8'h00;
         end else begin
            if (wr_en && wr_strb[gi]) begin
               mem_q[wr_idx] <= wr_data[8*gi +: 8];
            end
            rd_q <= rd_d;
         end
      end

      assign rd_data[8*gi +: 8] = rd_q;
   end

endmodule

// File: rtl/apb_dpmem.sv
// APB slave in front of a byte-strobed word RAM.
// state_d is the bus phase of the current cycle, derived from the phase of the
// previous cycle (state_q) and the live PSEL/PENABLE. Because every output is a
// flop, PREADY/PSLVERR/PRDATA for a cycle are decided at the edge before it:
// the completion cycle is the (WAIT_STATES+1)-th ACCESS cycle. Writes commit at
// the edge closing the completion cycle, using the ACCESS-phase bus values.
module apb_dpmem
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH  = APB_ADDR_WIDTH,
   parameter int DATA_WIDTH  = APB_DATA_WIDTH,
   parameter int MEM_DEPTH   = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic                    PSEL,
   input  logic                    PENABLE,
   input  logic                    PWRITE,
   input  logic [ADDR_WIDTH-1:0]   PADDR,
   input  logic [DATA_WIDTH-1:0]   PWDATA,
   input  logic [DATA_WIDTH/8-1:0] PSTRB,
   output logic [DATA_WIDTH-1:0]   PRDATA,
   output logic                    PREADY,
   output logic                    PSLVERR
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam int CNT_W = $clog2(WAIT_STATES + 2);
   // ACCESS-cycle count at which the following cycle is the completion cycle.
   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(WAIT_STATES);
   // ACCESS-cycle count reached by the completion cycle itself.
   localparam logic [CNT_W-1:0] DONE_CNT  = CNT_W'(WAIT_STATES + 1);

   apb_state_e       state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             pready_q, pready_d;
   logic             pslverr_q, pslverr_d;

   logic [ADDR_WIDTH-3:0] word_addr;
   logic [IDX_W-1:0]      word_idx;
   logic                  addr_err;
   logic                  rd_en;
   logic                  wr_en;

   // Unaligned or beyond-the-end addresses are errors.
   assign word_addr = PADDR[ADDR_WIDTH-1:2];
   assign word_idx  = PADDR[IDX_W+1:2];
   assign addr_err  = (PADDR[1:0] != 2'b00) ||
                      (word_addr >= (ADDR_WIDTH-2)'(MEM_DEPTH));

   // State, wait counter and registered bus outputs.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         pready_q   <= 1'b0;
         pslverr_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         pready_q   <= pready_d;
         pslverr_q  <= pslverr_d;
      end
   end

   // Phase of the current cycle plus the count of ACCESS cycles so far.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            // PENABLE without a preceding SETUP is ignored.
            state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
         end
         SETUP: begin
            state_d = (PSEL && PENABLE) ? ACCESS : IDLE;
         end
         ACCESS: begin
            if (wait_cnt_q == DONE_CNT) begin
               // Previous cycle completed; allow a back-to-back SETUP.
               state_d = (PSEL && !PENABLE) ? SETUP : IDLE;
            end else begin
               // Dropping PSEL (or PENABLE) while waiting aborts the transfer.
               state_d = (PSEL && PENABLE) ? ACCESS : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      wait_cnt_d = (state_d == ACCESS) ? wait_cnt_q + 1'b1 : '0;
   end

   // Decide next cycle's outputs and the RAM controls for this edge.
   always_comb begin
      pready_d  = ((state_d == SETUP) || (state_d == ACCESS)) &&
                  (wait_cnt_d == LAST_WAIT);
      pslverr_d = pready_d && addr_err;
      rd_en     = pready_d && !PWRITE && !addr_err;
      wr_en     = (state_d == ACCESS) && pready_q && PWRITE && !addr_err;
   end

   apb_dpmem_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (MEM_DEPTH),
      .IDX_W      (IDX_W)
   ) u_ram (
      .clk     (PCLK),
      .rst_n   (PRESETn),
      .wr_en   (wr_en),
      .wr_idx  (word_idx),
      .wr_data (PWDATA),
      .wr_strb (PSTRB),
      .rd_en   (rd_en),
      .rd_idx  (word_idx),
      .rd_data (PRDATA)
   );

   assign PREADY  = pready_q;
   assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_dpmem.sv
// Bench for apb_dpmem: one instance with WAIT_STATES=0 and one with 2, sharing
// the bus except for PSEL. A transaction-level model (per-instance memory
// image + predicted completion cycle) feeds per-cycle expectations that a
// single compare process checks at every falling edge; literal checks pin
// the model to hand-computed values.
module tb_apb_dpmem;
   import apb_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        psel0, psel2, penable, pwrite;
   addr_t       paddr;
   data_t       pwdata;
   logic [3:0]  pstrb;
   data_t       prdata0, prdata2;
   logic        pready0, pready2, pslverr0, pslverr2;

   logic        act_rdy   [2];
   logic        act_err   [2];
   data_t       act_rdata [2];
   logic        exp_rdy   [2];
   logic        exp_err   [2];
   data_t       exp_rdata [2];
   data_t       mem_m     [2][256];

   logic        chk_on;
   int          n_tests;
   int          n_fail;

   apb_dpmem #(.WAIT_STATES(0)) dut0 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel0), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
   );

   apb_dpmem #(.WAIT_STATES(2)) dut2 (
      .PCLK(clk), .PRESETn(rst_n), .PSEL(psel2), .PENABLE(penable),
      .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb),
      .PRDATA(prdata2), .PREADY(pready2), .PSLVERR(pslverr2)
   );

   assign act_rdy[0]   = pready0;
   assign act_rdy[1]   = pready2;
   assign act_err[0]   = pslverr0;
   assign act_err[1]   = pslverr2;
   assign act_rdata[0] = prdata0;
   assign act_rdata[1] = prdata2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Every cycle: both instances' outputs against the model's expectation.
   always @(negedge clk) begin
      if (chk_on) begin
         for (int d = 0; d < 2; d++) begin
            n_tests++;
            if ({act_rdy[d], act_err[d], act_rdata[d]} !==
                {exp_rdy[d], exp_err[d], exp_rdata[d]}) begin
               n_fail++;
               $display("FAIL cycle dut%0d t=%0t: ready/err/rdata got %0b/%0b/%h, want %0b/%0b/%h",
                        d, $time, act_rdy[d], act_err[d], act_rdata[d],
                        exp_rdy[d], exp_err[d], exp_rdata[d]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end else begin
         $display("[TB] ok %s = %h", name, got);
      end
   endtask

   task automatic clear_exp();
      for (int d = 0; d < 2; d++) begin
         exp_rdy[d]   = 1'b0;
         exp_err[d]   = 1'b0;
         exp_rdata[d] = '0;
      end
   endtask

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 256; i++) begin
            mem_m[d][i] = '0;
         end
      end
   endtask

   task automatic drive_sel(input int d);
      psel0 = (d == 0);
      psel2 = (d == 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         clear_exp();
         psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
      end
   endtask

   // One complete transfer; cyc = transfer cycle (SETUP = 1) on which PREADY was first seen.
   task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] strb,
                       output logic [31:0] rd, output logic err, output int cyc);
      int    ws;
      int    idx;
      bit    e;
      data_t er;
      ws  = (d == 0) ? 0 : 2;
      e   = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
      idx = int'(addr >> 2);
      er  = '0;
      if (!wr && !e) er = mem_m[d][idx];
      cyc = 0; rd = '0; err = 1'b0;
      @(posedge clk); #1;
      clear_exp();
      drive_sel(d); penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
      @(negedge clk);
      if (act_rdy[d]) cyc = 1;
      for (int k = 1; k <= ws + 1; k++) begin
         @(posedge clk); #1;
         penable = 1'b1;
         if (k == ws + 1) begin
            exp_rdy[d] = 1'b1; exp_err[d] = e; exp_rdata[d] = er;
         end
         @(negedge clk);
         if (act_rdy[d] && cyc == 0) cyc = k + 1;
         if (k == ws + 1) begin
            rd = act_rdata[d]; err = act_err[d];
         end
      end
      if (wr && !e) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) mem_m[d][idx][8*b +: 8] = wdata[8*b +: 8];
         end
      end
      $display("[TB] dut%0d %s addr=%h wdata=%h strb=%h -> rdata=%h err=%0b ready@%0d",
               d, wr ? "WR" : "RD", addr, wdata, strb, rd, err, cyc);
   endtask

   // Write started and then abandoned after n_pen ACCESS cycles (before completion).
   task automatic abort_xfer(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                             input int n_pen);
      @(posedge clk); #1;
      clear_exp();
      drive_sel(d); penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = wdata; pstrb = 4'hF;
      for (int k = 0; k < n_pen; k++) begin
         @(posedge clk); #1;
         penable = 1'b1;
      end
      @(posedge clk); #1;
      psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0;
      $display("[TB] dut%0d ABORT addr=%h after %0d access cycles", d, addr, n_pen);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          cyc;
      n_tests = 0; n_fail = 0; chk_on = 1'b0;
      rst_n = 1'b1;
      psel0 = 1'b0; psel2 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      clear_exp();
      clear_model();
      #1 rst_n = 1'b0;
      #1;
      check("reset pready0", {31'b0, pready0}, 32'h0);
      check("reset pslverr0", {31'b0, pslverr0}, 32'h0);
      check("reset prdata0", prdata0, 32'h0);
      check("reset pready2", {31'b0, pready2}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_on = 1'b1;

      // Read after reset is zero
      xfer(0, 0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
      check("t1 read 0x10", rd, 32'h0000_0000);
      check("t1 read 0x10 err", {31'b0, er}, 32'h0);

      // Full-word write then read, zero wait states
      xfer(0, 1, 32'h4, 32'hDEAD_BEEF, 4'hF, rd, er, cyc);
      check("t2 write ready cycle", cyc, 2);
      xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("t2 read 0x4", rd, 32'hDEAD_BEEF);
      check("t2 read ready cycle", cyc, 2);
      idle(1);

      // Strobed write keeps unstrobed lanes
      xfer(0, 1, 32'h4, 32'h1122_3344, 4'b0101, rd, er, cyc);
      xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("t3 strobed read 0x4", rd, 32'hDE22_BE44);

      // Out-of-range and unaligned accesses
      xfer(0, 1, 32'h400, 32'h1234_5678, 4'hF, rd, er, cyc);
      check("t4 write 0x400 err", {31'b0, er}, 32'h1);
      xfer(0, 0, 32'h6, 32'h0, 4'h0, rd, er, cyc);
      check("t4 read 0x6 err", {31'b0, er}, 32'h1);
      check("t4 read 0x6 rdata", rd, 32'h0);
      xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("t4 reread 0x4", rd, 32'hDE22_BE44);

      // Last valid word
      xfer(0, 1, 32'h3FC, 32'hA5A5_0F0F, 4'hF, rd, er, cyc);
      xfer(0, 0, 32'h3FC, 32'h0, 4'h0, rd, er, cyc);
      check("last word 0x3FC", rd, 32'hA5A5_0F0F);
      idle(2);

      // Two wait states
      xfer(1, 1, 32'h4, 32'hCAFE_F00D, 4'hF, rd, er, cyc);
      check("t5 write ready cycle", cyc, 4);
      xfer(1, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("t5 read 0x4", rd, 32'hCAFE_F00D);
      check("t5 read ready cycle", cyc, 4);
      xfer(1, 0, 32'h400, 32'h0, 4'h0, rd, er, cyc);
      check("t5 read 0x400 err", {31'b0, er}, 32'h1);

      // Aborted transfers must not write
      abort_xfer(1, 32'h4, 32'h0BAD_F00D, 1);
      abort_xfer(1, 32'h4, 32'h0BAD_F00D, 0);
      xfer(1, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("abort keeps 0x4", rd, 32'hCAFE_F00D);

      // PENABLE without SETUP is ignored by both instances
      repeat (3) begin
         @(posedge clk); #1;
         clear_exp();
         psel0 = 1'b1; psel2 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h4;
      end
      idle(1);
      xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("dut0 0x4 unaffected", rd, 32'hDE22_BE44);

      // Reset during the completion cycle of a write
      @(posedge clk); #1;
      clear_exp();
      drive_sel(0); penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h55AA_55AA; pstrb = 4'hF;
      @(posedge clk); #1;
      penable = 1'b1;
      exp_rdy[0] = 1'b1; exp_err[0] = 1'b0; exp_rdata[0] = '0;
      #1;
      check("t6 pready before reset", {31'b0, pready0}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("t6 pready in reset", {31'b0, pready0}, 32'h0);
      check("t6 pslverr in reset", {31'b0, pslverr0}, 32'h0);
      check("t6 prdata in reset", prdata0, 32'h0);
      clear_exp();
      clear_model();
      psel0 = 1'b0; penable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      xfer(0, 0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
      check("t6 read 0x8 after reset", rd, 32'h0);
      xfer(0, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("t6 dut0 0x4 cleared", rd, 32'h0);
      xfer(1, 0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
      check("t6 dut2 0x4 cleared", rd, 32'h0);
      idle(2);

      chk_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
